soc_system_switch_debounce: RTL

- Multi-channel synchroniser and debouncer for the board DIP switches and push buttons.
- Sits directly upstream of the switch PIO: its debounced_out drives the PIO in_port.
- Purpose: the PIO's two-flop edge detector sees exactly one clean transition per physical switch change.
- Also gives a per-channel one-cycle change strobe for fabric logic that bypasses the PIO.

---
 rtl/soc_system_switch_debounce.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/soc_system_switch_debounce.sv
// soc_system_switch_debounce
// Multi-channel synchroniser and debouncer for board DIP switches and push
// buttons. Each channel runs its own STABLE/QUALIFY machine so the PIO
// downstream sees exactly one clean transition per physical change, and
// fabric logic gets a one-cycle change strobe per channel.
// Optional build macro: SWITCH_DEBOUNCE_PRESCALE_EN adds a shared prescaler
// so qualification counters advance only once every PRESCALE clocks.
module soc_system_switch_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               CNT_WIDTH       = 20,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
`ifdef SWITCH_DEBOUNCE_PRESCALE_EN
  ,
  parameter int               PRESCALE        = 50000
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] change_pulse,
  output logic [WIDTH-1:0] qualifying
);

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic             tick;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser: raw pin levels shift through SYNC_STAGES flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_PRESCALE_EN
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_cnt;

  assign tick = (ps_cnt == PS_LAST);

  // Shared free-running prescaler; wraps at PRESCALE-1 where tick is raised
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_cnt <= '0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_ONE;
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 deb_q;
    logic                 pulse_q;
    logic                 qual_q;

    assign debounced_out[g] = deb_q;
    assign change_pulse[g]  = pulse_q;
    assign qualifying[g]    = qual_q;

    // Per-channel qualifier: a new level is accepted only after it persists
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state   <= STABLE;
        cnt     <= '0;
        deb_q   <= RESET_VALUE[g];
        pulse_q <= 1'b0;
        qual_q  <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state)
          STABLE: begin
            if (sync_s[g] == deb_q) begin
              cnt <= '0;
            end else if (DEBOUNCE_CYCLES == 1) begin
              deb_q   <= sync_s[g];
              pulse_q <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt    <= CNT_ONE;
              state  <= QUALIFY;
              qual_q <= 1'b1;
            end
          end
          QUALIFY: begin
            if (sync_s[g] == deb_q) begin
              cnt    <= '0;
              state  <= STABLE;
              qual_q <= 1'b0;
            end else if (tick) begin
              if (cnt == CNT_LAST) begin
                deb_q   <= sync_s[g];
                pulse_q <= 1'b1;
                cnt     <= '0;
                state   <= STABLE;
                qual_q  <= 1'b0;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          default: begin
            cnt    <= '0;
            state  <= STABLE;
            qual_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
